// File: rtl/tank_ctrl_pkg.sv
// Shared types and the stick-to-tread translation for the Ultra Tank input conditioner.
package tank_ctrl_pkg;

    localparam int unsigned DIR_UP    = 3;
    localparam int unsigned DIR_DOWN  = 2;
    localparam int unsigned DIR_LEFT  = 1;
    localparam int unsigned DIR_RIGHT = 0;

    // Conditioned request bits: dir1[3:0], dir2[7:4], fire[9:8], start[11:10], coin[12]
    localparam int unsigned NUM_IN = 13;

    typedef struct packed {
        logic fw;
        logic bk;
    } lever_t;

    typedef struct packed {
        lever_t l1;
        lever_t l2;
    } lever_pair_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

    // Key is {U,D,L,R}; result is {1Fw,1Bk,2Fw,2Bk}, active-high
    function automatic lever_pair_t dir_to_levers(input logic [3:0] dir);
        lever_pair_t lv;
        lv = '0;
        case (dir)
            4'b1010: lv = lever_pair_t'(4'b0010);
            4'b1000: lv = lever_pair_t'(4'b1010);
            4'b1001: lv = lever_pair_t'(4'b1000);
            4'b0001: lv = lever_pair_t'(4'b1001);
            4'b0101: lv = lever_pair_t'(4'b0100);
            4'b0100: lv = lever_pair_t'(4'b0101);
            4'b0110: lv = lever_pair_t'(4'b0001);
            4'b0010: lv = lever_pair_t'(4'b0110);
            default: lv = '0;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/tank_debounce.sv
// One-bit two-flop synchroniser followed by a stable-count debouncer.
module tank_debounce
    import tank_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 12000
) (
    input  logic clk_sys,
    input  logic Reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/tank_ctrl_mapper.sv
// Ultra Tank input conditioner: debounce, 8-way to tread levers, coin pulse shaping.
// Optional autofire is enabled by defining TANK_CTRL_AUTOFIRE_EN.
module tank_ctrl_mapper
    import tank_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES        = 12000,
    parameter int unsigned COIN_PULSE_CYCLES = 360000,
    parameter int unsigned COIN_GAP_CYCLES   = 1200000
`ifdef TANK_CTRL_AUTOFIRE_EN
    ,
    parameter int unsigned AUTOFIRE_HALF     = 600000
`endif
) (
    input  logic       clk_sys,
    input  logic       Reset_n,
    input  logic [3:0] dir1_i,
    input  logic [3:0] dir2_i,
    input  logic [1:0] fire_i,
    input  logic [1:0] start_i,
    input  logic       coin_i,
`ifdef TANK_CTRL_AUTOFIRE_EN
    input  logic [1:0] autofire_i,
`endif
    output logic [3:0] treads_a_n_o,
    output logic [3:0] treads_b_n_o,
    output logic [1:0] fire_o,
    output logic [1:0] start_n_o,
    output logic       coin_n_o
);

    localparam int unsigned CMAX = (COIN_GAP_CYCLES > COIN_PULSE_CYCLES) ?
                                   COIN_GAP_CYCLES : COIN_PULSE_CYCLES;
    localparam int unsigned CCW  = (CMAX > 1) ? $clog2(CMAX) : 1;

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] stable;
    logic [3:0]        st_dir1;
    logic [3:0]        st_dir2;
    logic [1:0]        st_fire;
    logic [1:0]        st_start;
    logic              st_coin;

    assign raw = {coin_i, start_i, fire_i, dir2_i, dir1_i};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
        tank_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk_sys(clk_sys),
            .Reset_n(Reset_n),
            .din    (raw[g]),
            .dout   (stable[g])
        );
    end

    assign st_dir1  = stable[3:0];
    assign st_dir2  = stable[7:4];
    assign st_fire  = stable[9:8];
    assign st_start = stable[11:10];
    assign st_coin  = stable[12];

    logic [3:0]  key1;
    logic [3:0]  key2;
    lever_pair_t lev1;
    lever_pair_t lev2;

    always_comb begin
        key1 = {st_dir1[DIR_UP], st_dir1[DIR_DOWN], st_dir1[DIR_LEFT], st_dir1[DIR_RIGHT]};
        key2 = {st_dir2[DIR_UP], st_dir2[DIR_DOWN], st_dir2[DIR_LEFT], st_dir2[DIR_RIGHT]};
        lev1 = dir_to_levers(key1);
        lev2 = dir_to_levers(key2);
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            treads_a_n_o <= 4'hF;
            treads_b_n_o <= 4'hF;
            start_n_o    <= 2'b11;
        end else begin
            treads_a_n_o <= ~{lev1.l1.fw, lev1.l1.bk, lev1.l2.fw, lev1.l2.bk};
            treads_b_n_o <= ~{lev2.l1.fw, lev2.l1.bk, lev2.l2.fw, lev2.l2.bk};
            start_n_o    <= ~st_start;
        end
    end

`ifdef TANK_CTRL_AUTOFIRE_EN
    localparam int unsigned AW = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

    logic [AW-1:0] af_cnt [2];
    logic [1:0]    af_phase;

    // Phase 0 drives high, so a fresh hold starts with a full high half-period
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int n = 0; n < 2; n++) begin
                af_cnt[n] <= '0;
            end
            af_phase <= '0;
            fire_o   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (!st_fire[n]) begin
                    af_cnt[n]   <= '0;
                    af_phase[n] <= 1'b0;
                end else if (af_cnt[n] == AW'(AUTOFIRE_HALF - 1)) begin
                    af_cnt[n]   <= '0;
                    af_phase[n] <= ~af_phase[n];
                end else begin
                    af_cnt[n] <= af_cnt[n] + 1'b1;
                end
                fire_o[n] <= st_fire[n] & (~autofire_i[n] | ~af_phase[n]);
            end
        end
    end
`else
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_o <= '0;
        end else begin
            fire_o <= st_fire;
        end
    end
`endif

    coin_state_t    coin_state;
    logic [CCW-1:0] coin_cnt;
    logic           coin_prev;
    logic           pending;
    logic           coin_rise;

    assign coin_rise = st_coin & ~coin_prev;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            coin_state <= IDLE;
            coin_cnt   <= '0;
            coin_prev  <= 1'b0;
            pending    <= 1'b0;
            coin_n_o   <= 1'b1;
        end else begin
            coin_prev <= st_coin;
            unique case (coin_state)
                IDLE: begin
                    if (coin_rise) begin
                        coin_state <= PULSE;
                        coin_cnt   <= '0;
                        coin_n_o   <= 1'b0;
                    end
                end
                PULSE: begin
                    if (coin_rise) begin
                        pending <= 1'b1;
                    end
                    if (coin_cnt == CCW'(COIN_PULSE_CYCLES - 1)) begin
                        coin_state <= GAP;
                        coin_cnt   <= '0;
                        coin_n_o   <= 1'b1;
                    end else begin
                        coin_cnt <= coin_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (coin_cnt == CCW'(COIN_GAP_CYCLES - 1)) begin
                        coin_cnt <= '0;
                        // A queued press restarts the pulse without passing through idle
                        if (pending || coin_rise) begin
                            coin_state <= PULSE;
                            pending    <= 1'b0;
                            coin_n_o   <= 1'b0;
                        end else begin
                            coin_state <= IDLE;
                        end
                    end else begin
                        coin_cnt <= coin_cnt + 1'b1;
                        if (coin_rise) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    coin_state <= IDLE;
                    coin_n_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tank_ctrl_mapper.sv
// Directed bench for tank_ctrl_mapper: vector table plus coin, debounce and reset sequences.
module tb_tank_ctrl_mapper;

    localparam int unsigned DEB   = 4;
    localparam int unsigned PULSE = 8;
    localparam int unsigned GAPC  = 6;

    logic       clk_sys = 1'b0;
    logic       Reset_n = 1'b1;
    logic [3:0] dir1_i  = '0;
    logic [3:0] dir2_i  = '0;
    logic [1:0] fire_i  = '0;
    logic [1:0] start_i = '0;
    logic       coin_i  = 1'b0;
    logic [1:0] autofire = '0;
    logic [3:0] treads_a_n_o;
    logic [3:0] treads_b_n_o;
    logic [1:0] fire_o;
    logic [1:0] start_n_o;
    logic       coin_n_o;

    tank_ctrl_mapper #(
        .DEB_CYCLES       (DEB),
        .COIN_PULSE_CYCLES(PULSE),
        .COIN_GAP_CYCLES  (GAPC)
`ifdef TANK_CTRL_AUTOFIRE_EN
        ,
        .AUTOFIRE_HALF    (3)
`endif
    ) dut (
        .clk_sys     (clk_sys),
        .Reset_n     (Reset_n),
        .dir1_i      (dir1_i),
        .dir2_i      (dir2_i),
        .fire_i      (fire_i),
        .start_i     (start_i),
        .coin_i      (coin_i),
`ifdef TANK_CTRL_AUTOFIRE_EN
        .autofire_i  (autofire),
`endif
        .treads_a_n_o(treads_a_n_o),
        .treads_b_n_o(treads_b_n_o),
        .fire_o      (fire_o),
        .start_n_o   (start_n_o),
        .coin_n_o    (coin_n_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        logic [1:0] fire;
        logic [1:0] start;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [1:0] ef;
        logic [1:0] es;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns just after the n-th following rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i < hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_treads_a"}, 64'(treads_a_n_o), 64'hF);
        check({tag, "_treads_b"}, 64'(treads_b_n_o), 64'hF);
        check({tag, "_start_n"}, 64'(start_n_o), 64'h3);
        check({tag, "_coin_n"}, 64'(coin_n_o), 64'h1);
        check({tag, "_fire"}, 64'(fire_o), 64'h0);
    endtask

    // Press j is high after edges 8j..8j+3; held mode keeps coin high for `hold` samples
    task automatic coin_window(input int npress, input int hold, input int nsamp,
                               output logic [63:0] lows);
        lows   = '0;
        coin_i = 1'b1;
        for (int i = 1; i <= nsamp; i++) begin
            tick(1);
            lows[i] = ~coin_n_o;
            if (npress > 0) coin_i = ((i / 8) < npress) && ((i % 8) < 4);
            else            coin_i = (i < hold);
        end
        coin_i = 1'b0;
    endtask

    logic [63:0] lows;
    int          dev;

    initial begin
        tbl[0]  = '{4'b1000, 4'b0010, 2'b01, 2'b00, 4'b0101, 4'b1001, 2'b01, 2'b11};
        tbl[1]  = '{4'b1010, 4'b0110, 2'b10, 2'b01, 4'b1101, 4'b1110, 2'b10, 2'b10};
        tbl[2]  = '{4'b1001, 4'b0100, 2'b11, 2'b10, 4'b0111, 4'b1010, 2'b11, 2'b01};
        tbl[3]  = '{4'b0001, 4'b0101, 2'b00, 2'b11, 4'b0110, 4'b1011, 2'b00, 2'b00};
        tbl[4]  = '{4'b0101, 4'b0001, 2'b01, 2'b00, 4'b1011, 4'b0110, 2'b01, 2'b11};
        tbl[5]  = '{4'b0100, 4'b1001, 2'b10, 2'b01, 4'b1010, 4'b0111, 2'b10, 2'b10};
        tbl[6]  = '{4'b0110, 4'b1010, 2'b11, 2'b10, 4'b1110, 4'b1101, 2'b11, 2'b01};
        tbl[7]  = '{4'b0010, 4'b1000, 2'b00, 2'b11, 4'b1001, 4'b0101, 2'b00, 2'b00};
        tbl[8]  = '{4'b1100, 4'b0011, 2'b01, 2'b00, 4'b1111, 4'b1111, 2'b01, 2'b11};
        tbl[9]  = '{4'b1110, 4'b1111, 2'b10, 2'b01, 4'b1111, 4'b1111, 2'b10, 2'b10};
        tbl[10] = '{4'b0000, 4'b1011, 2'b11, 2'b10, 4'b1111, 4'b1111, 2'b11, 2'b01};
        tbl[11] = '{4'b0111, 4'b1101, 2'b00, 2'b11, 4'b1111, 4'b1111, 2'b00, 2'b00};

        // Power-on reset and idle hold
        #1 Reset_n = 1'b0;
        tick(3);
        #2 Reset_n = 1'b1;
        tick(1);
        check_reset_vals("por");
        dev = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (treads_a_n_o !== 4'hF || treads_b_n_o !== 4'hF || start_n_o !== 2'b11 ||
                coin_n_o !== 1'b1 || fire_o !== 2'b00) dev++;
        end
        check("idle_hold_deviations", 64'(dev), 64'd0);

        // Steady-state mapping table
        for (int i = 0; i < 12; i++) begin
            dir1_i  = tbl[i].d1;
            dir2_i  = tbl[i].d2;
            fire_i  = tbl[i].fire;
            start_i = tbl[i].start;
            tick(10);
            check($sformatf("tbl%0d_treads_a", i), 64'(treads_a_n_o), 64'(tbl[i].ea));
            check($sformatf("tbl%0d_treads_b", i), 64'(treads_b_n_o), 64'(tbl[i].eb));
            check($sformatf("tbl%0d_fire", i), 64'(fire_o), 64'(tbl[i].ef));
            check($sformatf("tbl%0d_start_n", i), 64'(start_n_o), 64'(tbl[i].es));
        end

        // Asynchronous reset mid-cycle with active outputs
        dir1_i  = 4'b1000;
        dir2_i  = 4'b0001;
        fire_i  = 2'b11;
        start_i = 2'b11;
        tick(10);
        check("pre_reset_treads_a", 64'(treads_a_n_o), 64'h5);
        @(posedge clk_sys);
        #3 Reset_n = 1'b0;
        #1 check_reset_vals("async");
        dir1_i  = '0;
        dir2_i  = '0;
        fire_i  = '0;
        start_i = '0;
        #10 Reset_n = 1'b1;
        tick(12);

        // Mapping latency: output follows seven edges after the input is applied
        dir1_i = 4'b1000;
        tick(6);
        check("map_lat_before", 64'(treads_a_n_o), 64'hF);
        tick(1);
        check("map_lat_edge", 64'(treads_a_n_o), 64'h5);
        dir1_i = 4'b0101;
        tick(10);
        check("map_down_right", 64'(treads_a_n_o), 64'hB);
        dir1_i = 4'b1100;
        tick(10);
        check("map_opposite", 64'(treads_a_n_o), 64'hF);
        dir1_i = 4'b0000;
        tick(10);

        // Debounce: a 3-cycle glitch is ignored, a 4-cycle pulse passes
        dir2_i = 4'b0001;
        tick(3);
        dir2_i = 4'b0000;
        dev = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (treads_b_n_o !== 4'hF) dev++;
        end
        check("deb_glitch3_deviations", 64'(dev), 64'd0);
        dir2_i = 4'b0001;
        tick(4);
        dir2_i = 4'b0000;
        tick(2);
        check("deb_pulse4_before", 64'(treads_b_n_o), 64'hF);
        tick(1);
        check("deb_pulse4_on", 64'(treads_b_n_o), 64'h6);
        tick(15);
        check("deb_pulse4_release", 64'(treads_b_n_o), 64'hF);

        // Coin burst: four presses; second and third chain, fourth is dropped
        coin_window(4, 0, 60, lows);
        check("coin_burst_lows", lows, span(7, 15) | span(21, 29) | span(35, 43));
        tick(20);

        // Coin held continuously gives a single pulse
        coin_window(0, 40, 60, lows);
        check("coin_held_lows", lows, span(7, 15));
        tick(20);

        // Reset during the second pulse with a press pending
        coin_i = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick(1);
            coin_i = ((i / 8) < 3) && ((i % 8) < 4);
        end
        coin_i = 1'b0;
        check("coin_pre_reset_low", 64'(coin_n_o), 64'h0);
        #2 Reset_n = 1'b0;
        #1 check("coin_async_reset", 64'(coin_n_o), 64'h1);
        #10 Reset_n = 1'b1;
        dev = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (coin_n_o !== 1'b1) dev++;
        end
        check("coin_after_reset_lows", 64'(dev), 64'd0);

`ifdef TANK_CTRL_AUTOFIRE_EN
        // Autofire on player A: high for 3, low for 3, from the first held cycle
        autofire = 2'b01;
        fire_i   = 2'b01;
        lows     = '0;
        dev      = 0;
        for (int i = 1; i <= 18; i++) begin
            tick(1);
            lows[i] = fire_o[0];
            if (fire_o[1] !== 1'b0) dev++;
        end
        check("autofire_a_pattern", lows, span(7, 10) | span(13, 16));
        check("autofire_b_quiet", 64'(dev), 64'd0);
        fire_i = 2'b00;
        tick(10);
        check("autofire_release", 64'(fire_o), 64'h0);
        autofire = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
